lm70_spi_responder: RTL and testbench
=====================================

# lm70_spi_responder

Synchronous model of the LM70 side of the temperature-sensor SPI link: it answers the digital temperature monitor's SPI master on CS/SCK/SIO. It serialises an 11-bit two's-complement temperature word, then accepts an optional 16-bit configuration write on the same SIO line. It supports the LM70 shutdown command, and returns the manufacturer ID while shut down. It sits on the sensor side of the uio pins, as a silicon self-test target and as a bench stand-in for the real sensor. The system clock oversamples SCK and CS.

## Interface
- FRAME_PAD, default 5'b11111: five LSBs appended below the temperature word in each read frame.
- SHDN_CMD, default 16'h00FF: write value that enters shutdown.
- MFR_ID, default 16'h800F: read frame returned while in shutdown.

- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  asynchronous, active-low reset.
- cs_n  input  1  SPI chip select from the master, asynchronous to clk.
- sck  input  1  SPI clock from the master, idle low, asynchronous to clk.
- sio_in  input  1  SIO pad input, used in the write phase.
- sio_out  output  1  SIO pad output data.
- sio_oe  output  1  SIO pad output enable, active high.
- temp_in  input  11  temperature, two's complement, 0.25 °C/LSB.
- shutdown  output  1  shutdown mode flag.
- frame_done  output  1  one-clk pulse at the end of a frame that had at least 16 read bits.

## Operation
- **Synchronisers:** cs_n and sck each pass through two flops, then a third history flop.
  - Edges are detected from stage 2 against stage 3.
  - The synchronised value of cs_n/sck is the stage-2 value.
  - All logic acts only on the detected edges.
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE:** sio_oe=0, sio_out=0.
  - On a cs_n falling edge, load the 16-bit shift register:
    - normal mode: {temp_in, FRAME_PAD};
    - shutdown mode: MFR_ID.
  - Clear bit_cnt (6 bits), drive sio_out=shift[15], sio_oe=1, go to READ.
  - temp_in is sampled only at that edge; later changes do not affect the frame.
- **READ:**
  - Each sck rising edge increments bit_cnt.
  - Each sck falling edge with bit_cnt<16: shift left, sio_out = new shift[15].
  - sck falling edge with bit_cnt==16: sio_oe=0, clear the command register, go to WRITE.
- **WRITE:** sio_oe=0.
  - Each sck rising edge: cmd <= {cmd[14:0], sio_in}, bit_cnt++.
  - At bit_cnt==32, go to DONE.
- **DONE:** further sck edges are ignored, and bit_cnt saturates at 32.
- **cs_n rising edge, any state:** go to IDLE, sio_oe=0.
  - frame_done pulses if bit_cnt>=16.
  - If bit_cnt==32, commit the command: cmd==SHDN_CMD sets shutdown=1, and any other complete command clears it.
  - Writes shorter than 16 bits are discarded and shutdown is unchanged.
- **Short frames:** a frame aborted before 16 read bits does not pulse frame_done and does not change shutdown. For example, the monitor reads only 8 SCK cycles.
- **Simultaneous edges:** a cs_n edge and an sck edge detected in the same clk are resolved by cs_n; the sck edge is ignored.

## Timing
- **Reset:** rst_n low forces all of the following, asynchronously:
  - state=IDLE, bit_cnt=0, shift=0, cmd=0;
  - sio_out=0, sio_oe=0, shutdown=0, frame_done=0;
  - synchroniser flops=0. cs_n reset-low does not count as a falling edge; an edge is needed.
- **Reset mid-frame:** the frame is abandoned and the next frame starts clean. A pending command is not committed.
- **Pin latency:** a pin change first sampled at clk edge N is acted on at edge N+2.
  - sio_out, sio_oe and shutdown change at N+2.
  - frame_done is high for the cycle following edge N+2.
- **First bit:** after cs_n falls, MSB data is valid on sio_out 2 clk later. Later bits are valid 2 clk after each sck falling edge.
- **SCK timing limits:**
  - sck high and low phases must each last ≥3 clk.
  - cs_n must fall ≥3 clk before the first sck rising edge.
  - Under these limits the master sees data stable at its sampling edge. Faster SCK is out of specification.
- **Output registration:** all outputs are registered; there are no combinational paths from any input to any output.

## Test plan
- **Read frame:** temp_in=11'h0C8 (+50 °C), cs_n low, 16 sck cycles of 8 clk period -> sampled SIO = 16'h191F; frame_done pulses once at cs_n high; sio_oe low after the 16th falling edge.
- **Negative temperature and frame coherence:** temp_in=11'h7FC (−1 °C), then change temp_in mid-frame -> 16'hFF9F, unaffected by the change.
- **Shutdown entry and exit:**
  - Write 16'h00FF after a read -> shutdown=1, and the next read returns 16'h800F.
  - Write 16'h0000 -> shutdown=0, and normal data returns.
- **Partial frames:**
  - Abort after 8 sck cycles -> first 8 bits correct, no frame_done, shutdown unchanged.
  - Abort a write after 10 bits of 00FF -> shutdown unchanged.
- **Reset and synchronisation:**
  - Assert rst_n low mid-write, release -> all outputs 0, and the next full frame is correct.
  - Drive cs_n and sck asynchronous to clk with jittered edges (≥3 clk phases) -> bit-exact frames over 100 random temperatures.

Source files
------------

// File: rtl/lm70_spi_responder.sv
// LM70-style SPI responder: serialises {temp_in, FRAME_PAD} (or MFR_ID in shutdown), then accepts a 16-bit command.
// cs_n/sck are oversampled by clk through 2-flop synchronisers plus a history flop; all outputs are registered.
`timescale 1ns/1ps
module lm70_spi_responder #(
  parameter logic [4:0]  FRAME_PAD = 5'b11111,
  parameter logic [15:0] SHDN_CMD  = 16'h00FF,
  parameter logic [15:0] MFR_ID    = 16'h800F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sck,
  input  logic        sio_in,
  output logic        sio_out,
  output logic        sio_oe,
  input  logic [10:0] temp_in,
  output logic        shutdown,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  cs_sync;
  logic [2:0]  sck_sync;
  logic [5:0]  bit_cnt;
  logic [15:0] shift;
  logic [15:0] cmd;

  // [0] first sync stage, [1] synchronised value, [2] history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync  <= 3'b000;
      sck_sync <= 3'b000;
    end else begin
      cs_sync  <= {cs_sync[1:0], cs_n};
      sck_sync <= {sck_sync[1:0], sck};
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall;
  assign cs_fall  =  cs_sync[2]  & ~cs_sync[1];
  assign cs_rise  = ~cs_sync[2]  &  cs_sync[1];
  assign sck_rise = ~sck_sync[2] &  sck_sync[1];
  assign sck_fall =  sck_sync[2] & ~sck_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 6'd0;
      shift      <= 16'h0000;
      cmd        <= 16'h0000;
      sio_out    <= 1'b0;
      sio_oe     <= 1'b0;
      shutdown   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // cs_n edges take priority over any sck edge seen in the same cycle
      if (cs_rise) begin
        state      <= IDLE;
        sio_oe     <= 1'b0;
        sio_out    <= 1'b0;
        frame_done <= (bit_cnt >= 6'd16);
        if (bit_cnt == 6'd32)
          shutdown <= (cmd == SHDN_CMD);
      end else if (cs_fall) begin
        if (state == IDLE) begin
          shift   <= shutdown ? MFR_ID : {temp_in, FRAME_PAD};
          sio_out <= shutdown ? MFR_ID[15] : temp_in[10];
          sio_oe  <= 1'b1;
          bit_cnt <= 6'd0;
          state   <= READ;
        end
      end else begin
        case (state)
          IDLE: begin
            sio_oe  <= 1'b0;
            sio_out <= 1'b0;
          end
          READ: begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 6'd1;
            end else if (sck_fall) begin
              if (bit_cnt < 6'd16) begin
                shift   <= {shift[14:0], 1'b0};
                sio_out <= shift[14];
              end else begin
                sio_oe  <= 1'b0;
                sio_out <= 1'b0;
                cmd     <= 16'h0000;
                state   <= WRITE;
              end
            end
          end
          WRITE: begin
            sio_oe <= 1'b0;
            if (sck_rise) begin
              cmd     <= {cmd[14:0], sio_in};
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd31)
                state <= DONE;
            end
          end
          DONE: begin
            sio_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Directed bench for lm70_spi_responder: acts as the SPI master, checks read data, frame_done and shutdown.
`timescale 1ns/1ps
module tb_lm70_spi_responder;

  logic        clk;
  logic        rst_n;
  logic        cs_n;
  logic        sck;
  logic        sio_in;
  logic        sio_out;
  logic        sio_oe;
  logic [10:0] temp_in;
  logic        shutdown;
  logic        frame_done;

  int checks;
  int errors;
  int fd_cnt;

  lm70_spi_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .sck        (sck),
    .sio_in     (sio_in),
    .sio_out    (sio_out),
    .sio_oe     (sio_oe),
    .temp_in    (temp_in),
    .shutdown   (shutdown),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  function automatic int hd(input int jit);
    return 40 + int'($urandom_range(jit, 0));
  endfunction

  // One master frame: nread SCK cycles sampling SIO on rising edges, then nwrite command bits.
  task automatic frame(input int nread, input int nwrite, input logic [15:0] wdat, input int jit,
                       input int chg_bit, input logic [10:0] chg_val, input bit rst_end,
                       output logic [15:0] rdat, output logic oe_mid, output logic oe_after);
    rdat = 16'h0000;
    cs_n = 1'b0;
    #(hd(jit));
    oe_mid = sio_oe;
    for (int i = 0; i < nread; i++) begin
      if (i == chg_bit) temp_in = chg_val;
      sck = 1'b1;
      rdat[15-i] = sio_out;
      #(hd(jit));
      sck = 1'b0;
      #(hd(jit));
    end
    oe_after = sio_oe;
    for (int j = 0; j < nwrite; j++) begin
      sio_in = wdat[15-j];
      #(hd(jit));
      sck = 1'b1;
      #(hd(jit));
      sck = 1'b0;
    end
    #(hd(jit));
    if (rst_end) begin
      rst_n = 1'b0;
      #25;
      cs_n   = 1'b1;
      sck    = 1'b0;
      sio_in = 1'b0;
      #20;
      rst_n = 1'b1;
    end else begin
      cs_n = 1'b1;
    end
    sio_in = 1'b0;
    #100;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({sio_out, sio_oe, shutdown, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {sio_out, sio_oe, shutdown, frame_done});
    end
    rst_n = 1'b1;
    #60;
    checks++;
    if ({sio_out, sio_oe, frame_done} !== 3'b000 || fd_cnt !== 0) begin
      errors++;
      $display("FAIL post_reset_idle got %b fd %0d exp 000 fd 0", {sio_out, sio_oe, frame_done}, fd_cnt);
    end
  endtask

  task automatic test_read();
    logic [15:0] rd;
    logic oe_m, oe_a;
    int fd0;
    temp_in = 11'h0C8;
    fd0 = fd_cnt;
    frame(16, 0, 16'h0, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (rd !== 16'h191F) begin errors++; $display("FAIL read_data got %h exp 191f", rd); end
    checks++;
    if (oe_m !== 1'b1) begin errors++; $display("FAIL read_oe got %b exp 1", oe_m); end
    checks++;
    if (oe_a !== 1'b0) begin errors++; $display("FAIL oe_after_16 got %b exp 0", oe_a); end
    checks++;
    if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL read_frame_done got %0d exp 1", fd_cnt - fd0); end
    checks++;
    if ({sio_out, sio_oe, shutdown} !== 3'b000) begin
      errors++;
      $display("FAIL read_idle got %b exp 000", {sio_out, sio_oe, shutdown});
    end
  endtask

  task automatic test_coherence();
    logic [15:0] rd;
    logic oe_m, oe_a;
    temp_in = 11'h7FC;
    frame(16, 0, 16'h0, 0, 5, 11'h123, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (rd !== 16'hFF9F) begin errors++; $display("FAIL neg_coherent got %h exp ff9f", rd); end
  endtask

  task automatic test_shutdown();
    logic [15:0] rd;
    logic oe_m, oe_a;
    int fd0;
    temp_in = 11'h0C8;
    frame(16, 16, 16'h00FF, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (shutdown !== 1'b1) begin errors++; $display("FAIL shdn_enter got %b exp 1", shutdown); end
    frame(16, 0, 16'h0, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (rd !== 16'h800F) begin errors++; $display("FAIL shdn_mfr_id got %h exp 800f", rd); end
    fd0 = fd_cnt;
    frame(8, 0, 16'h0, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (rd[15:8] !== 8'h80) begin errors++; $display("FAIL partial8_bits got %h exp 80", rd[15:8]); end
    checks++;
    if (fd_cnt - fd0 !== 0) begin errors++; $display("FAIL partial8_frame_done got %0d exp 0", fd_cnt - fd0); end
    checks++;
    if (shutdown !== 1'b1) begin errors++; $display("FAIL partial8_shdn got %b exp 1", shutdown); end
    frame(16, 10, 16'h0000, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (shutdown !== 1'b1) begin errors++; $display("FAIL short_write_exit got %b exp 1", shutdown); end
    frame(16, 16, 16'h0000, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (shutdown !== 1'b0) begin errors++; $display("FAIL shdn_exit got %b exp 0", shutdown); end
    frame(16, 0, 16'h0, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (rd !== 16'h191F) begin errors++; $display("FAIL normal_after_exit got %h exp 191f", rd); end
  endtask

  task automatic test_partial_write();
    logic [15:0] rd;
    logic oe_m, oe_a;
    frame(16, 10, 16'h00FF, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (shutdown !== 1'b0) begin errors++; $display("FAIL short_write_enter got %b exp 0", shutdown); end
  endtask

  task automatic test_reset_midwrite();
    logic [15:0] rd;
    logic oe_m, oe_a;
    int fd0;
    frame(16, 16, 16'h00FF, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    fd0 = fd_cnt;
    frame(16, 16, 16'h00FF, 0, -1, 11'h0, 1'b1, rd, oe_m, oe_a);
    checks++;
    if ({sio_out, sio_oe, shutdown} !== 3'b000 || fd_cnt !== fd0) begin
      errors++;
      $display("FAIL reset_midwrite got %b fd %0d exp 000 fd %0d", {sio_out, sio_oe, shutdown}, fd_cnt, fd0);
    end
    temp_in = 11'h3A5;
    frame(16, 0, 16'h0, 0, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
    checks++;
    if (rd !== 16'h74BF) begin errors++; $display("FAIL after_reset_read got %h exp 74bf", rd); end
  endtask

  task automatic test_random();
    logic [15:0] rd;
    logic oe_m, oe_a;
    logic [10:0] t;
    int fd0;
    fd0 = fd_cnt;
    for (int k = 0; k < 100; k++) begin
      t = 11'($urandom_range(2047, 0));
      temp_in = t;
      #($urandom_range(13, 1));
      frame(16, 0, 16'h0, 15, -1, 11'h0, 1'b0, rd, oe_m, oe_a);
      checks++;
      if (rd !== {t, 5'b11111}) begin
        errors++;
        $display("FAIL random_frame %0d got %h exp %h", k, rd, {t, 5'b11111});
      end
    end
    checks++;
    if (fd_cnt - fd0 !== 100) begin errors++; $display("FAIL random_frame_done got %0d exp 100", fd_cnt - fd0); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    fd_cnt  = 0;
    rst_n   = 1'b0;
    cs_n    = 1'b1;
    sck     = 1'b0;
    sio_in  = 1'b0;
    temp_in = 11'h000;
    test_reset();
    test_read();
    test_coherence();
    test_shutdown();
    test_partial_write();
    test_reset_midwrite();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
